// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a single-accumulator multicycle CPU.
// Optional `SINGLE_STEP_EN adds a step input that holds the machine in FETCH until stepped.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
`ifdef SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic       MemRead,
    output logic       MemWrite,
    output logic       ldIR,
    output logic       ldMDR,
    output logic       ldAcc,
    output logic       IorD,
    output logic       Asrc,
    output logic [1:0] Bsrc,
    output logic       PCsrc,
    output logic       PCwrite,
    output logic       jz,
    output logic       AccSrc,
    output logic [1:0] ALUop
);

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_JZ  = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMRD  = 4'd2,
        S_LDWB   = 4'd3,
        S_ALUWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_NOTWB  = 4'd6,
        S_JUMP   = 4'd7,
        S_JZERO  = 4'd8
    } state_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ld_ir;
        logic       ld_mdr;
        logic       ld_acc;
        logic       iord;
        logic       asrc;
        logic [1:0] bsrc;
        logic       pcsrc;
        logic       pcwrite;
        logic       jz;
        logic       acc_src;
        logic [1:0] aluop;
    } ctrl_t;

    state_t     state;
    logic [2:0] op_q;
    logic       fetch_go;
    ctrl_t      ctrl;

`ifdef SINGLE_STEP_EN
    logic armed;
    assign fetch_go = armed;
`else
    assign fetch_go = 1'b1;
`endif

    // op_q is captured as DECODE is left so later states ignore opcode changes on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            op_q  <= OP_LDA;
`ifdef SINGLE_STEP_EN
            armed <= 1'b0;
`endif
        end else begin
`ifdef SINGLE_STEP_EN
            if (state == S_FETCH)
                armed <= armed ? 1'b0 : step;
            else
                armed <= 1'b0;
`endif
            case (state)
                S_FETCH: begin
                    if (fetch_go)
                        state <= S_DECODE;
                end
                S_DECODE: begin
                    op_q <= opcode;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_AND: state <= S_MEMRD;
                        OP_STA:                         state <= S_MEMWR;
                        OP_NOT:                         state <= S_NOTWB;
                        OP_JMP:                         state <= S_JUMP;
                        OP_JZ:                          state <= S_JZERO;
                        default:                        state <= S_FETCH;
                    endcase
                end
                S_MEMRD: begin
                    if (op_q == OP_LDA)
                        state <= S_LDWB;
                    else
                        state <= S_ALUWB;
                end
                S_LDWB:  state <= S_FETCH;
                S_ALUWB: state <= S_FETCH;
                S_MEMWR: state <= S_FETCH;
                S_NOTWB: state <= S_FETCH;
                S_JUMP:  state <= S_FETCH;
                S_JZERO: state <= S_FETCH;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Output decode depends only on the state register and the latched opcode.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                if (fetch_go) begin
                    ctrl.mem_read = 1'b1;
                    ctrl.ld_ir    = 1'b1;
                    ctrl.bsrc     = 2'b01;
                    ctrl.aluop    = ALU_ADD;
                    ctrl.pcwrite  = 1'b1;
                end
            end
            S_DECODE: ctrl = '0;
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.ld_mdr   = 1'b1;
            end
            S_LDWB: begin
                ctrl.acc_src = 1'b1;
                ctrl.ld_acc  = 1'b1;
            end
            S_ALUWB: begin
                ctrl.asrc   = 1'b1;
                ctrl.bsrc   = 2'b10;
                ctrl.ld_acc = 1'b1;
                case (op_q)
                    OP_SUB:  ctrl.aluop = ALU_SUB;
                    OP_AND:  ctrl.aluop = ALU_AND;
                    default: ctrl.aluop = ALU_ADD;
                endcase
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_NOTWB: begin
                ctrl.asrc   = 1'b1;
                ctrl.aluop  = ALU_NOT;
                ctrl.ld_acc = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcsrc   = 1'b1;
                ctrl.pcwrite = 1'b1;
            end
            S_JZERO: begin
                ctrl.asrc  = 1'b1;
                ctrl.bsrc  = 2'b00;
                ctrl.aluop = ALU_ADD;
                ctrl.pcsrc = 1'b1;
                ctrl.jz    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // Gating with rst_n kills every strobe the instant reset asserts, without waiting for a clock.
    assign {MemRead, MemWrite, ldIR, ldMDR, ldAcc, IorD, Asrc, Bsrc,
            PCsrc, PCwrite, jz, AccSrc, ALUop} = rst_n ? ctrl : '0;

endmodule
